// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller: TAP FSM, 4-bit IR, bypass/IDCODE registers, BSR strobes and TDO mux.
// Latency: state, IR and data registers update on the rising TCK edge; strobes and TDO are combinational from registered state.
// Backpressure: none; the FSM advances on every TCK edge under TMS control.
module jtag_tap_ctrl #(
    parameter int          IR_WIDTH   = 4,
    parameter logic [31:0] IDCODE_VAL = 32'h1000_0001
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    input  logic                bsr_tdo,
    output logic                TDO,
    output logic                TDO_en,
    output logic                dr_capture,
    output logic                dr_shift,
    output logic                dr_update,
    output logic                bsr_select,
    output logic                mode,
    output logic [3:0]          tap_state,
    output logic [IR_WIDTH-1:0] ir_out
);

    typedef enum logic [3:0] {
        TLR    = 4'hF, RTI    = 4'hC,
        SEL_DR = 4'h7, CAP_DR = 4'h6, SH_DR = 4'h2, EX1_DR = 4'h1,
        PAU_DR = 4'h3, EX2_DR = 4'h0, UPD_DR = 4'h5,
        SEL_IR = 4'h4, CAP_IR = 4'hE, SH_IR = 4'hA, EX1_IR = 4'h9,
        PAU_IR = 4'hB, EX2_IR = 4'h8, UPD_IR = 4'hD
    } tap_state_e;

    localparam logic [IR_WIDTH-1:0] OP_EXTEST  = IR_WIDTH'(4'h0);
    localparam logic [IR_WIDTH-1:0] OP_SAMPLE  = IR_WIDTH'(4'h1);
    localparam logic [IR_WIDTH-1:0] OP_IDCODE  = IR_WIDTH'(4'h2);
    localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(4'h1);

    tap_state_e          state_q, state_d;
    logic [IR_WIDTH-1:0] ir_out_q, ir_out_d;
    logic [IR_WIDTH-1:0] ir_sr_q, ir_sr_d;
    logic                bypass_q, bypass_d;
    logic [31:0]         idcode_sr_q, idcode_sr_d;

    // Instruction decode; anything not explicitly listed behaves as BYPASS
    logic is_extest, is_sample, is_idcode, is_bypass;
    assign is_extest = (ir_out_q == OP_EXTEST);
    assign is_sample = (ir_out_q == OP_SAMPLE);
    assign is_idcode = (ir_out_q == OP_IDCODE);
    assign is_bypass = !(is_extest || is_sample || is_idcode);

    // State register: TRST drops straight into Test-Logic-Reset
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) state_q <= TLR;
        else       state_q <= state_d;
    end

    // Next-state logic from TMS
    always_comb begin
        state_d = state_q;
        case (state_q)
            TLR:    state_d = TMS ? TLR    : RTI;
            RTI:    state_d = TMS ? SEL_DR : RTI;
            SEL_DR: state_d = TMS ? SEL_IR : CAP_DR;
            CAP_DR: state_d = TMS ? EX1_DR : SH_DR;
            SH_DR:  state_d = TMS ? EX1_DR : SH_DR;
            EX1_DR: state_d = TMS ? UPD_DR : PAU_DR;
            PAU_DR: state_d = TMS ? EX2_DR : PAU_DR;
            EX2_DR: state_d = TMS ? UPD_DR : SH_DR;
            UPD_DR: state_d = TMS ? SEL_DR : RTI;
            SEL_IR: state_d = TMS ? TLR    : CAP_IR;
            CAP_IR: state_d = TMS ? EX1_IR : SH_IR;
            SH_IR:  state_d = TMS ? EX1_IR : SH_IR;
            EX1_IR: state_d = TMS ? UPD_IR : PAU_IR;
            PAU_IR: state_d = TMS ? EX2_IR : PAU_IR;
            EX2_IR: state_d = TMS ? UPD_IR : SH_IR;
            UPD_IR: state_d = TMS ? SEL_DR : RTI;
            default: state_d = TLR;
        endcase
    end

    // Outputs: BSR strobes, instruction-driven controls and the TDO return mux
    always_comb begin
        tap_state  = state_q;
        ir_out     = ir_out_q;
        bsr_select = is_extest || is_sample;
        mode       = is_extest;
        dr_capture = (state_q == CAP_DR) && bsr_select;
        dr_shift   = (state_q == SH_DR)  && bsr_select;
        dr_update  = (state_q == UPD_DR) && bsr_select;
        TDO_en     = (state_q == SH_DR) || (state_q == SH_IR);
        TDO        = 1'b0;
        if (state_q == SH_IR) begin
            TDO = ir_sr_q[0];
        end else if (state_q == SH_DR) begin
            if (bsr_select)     TDO = bsr_tdo;
            else if (is_idcode) TDO = idcode_sr_q[0];
            else                TDO = bypass_q;
        end
    end

    // Register next values: IR capture/shift/update and the selected data register
    always_comb begin
        ir_sr_d     = ir_sr_q;
        ir_out_d    = ir_out_q;
        bypass_d    = bypass_q;
        idcode_sr_d = idcode_sr_q;
        case (state_q)
            CAP_IR: ir_sr_d  = IR_CAPTURE;
            SH_IR:  ir_sr_d  = {TDI, ir_sr_q[IR_WIDTH-1:1]};
            UPD_IR: ir_out_d = ir_sr_q;
            CAP_DR: begin
                if (is_bypass) bypass_d    = 1'b0;
                if (is_idcode) idcode_sr_d = IDCODE_VAL;
            end
            SH_DR: begin
                if (is_bypass) bypass_d    = TDI;
                if (is_idcode) idcode_sr_d = {TDI, idcode_sr_q[31:1]};
            end
            default: ;
        endcase
        // Landing in Test-Logic-Reset always reselects IDCODE
        if (state_d == TLR) ir_out_d = OP_IDCODE;
    end

    // IR and data registers; TRST aborts any scan in progress
    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            ir_out_q    <= OP_IDCODE;
            ir_sr_q     <= '0;
            bypass_q    <= 1'b0;
            idcode_sr_q <= '0;
        end else begin
            ir_out_q    <= ir_out_d;
            ir_sr_q     <= ir_sr_d;
            bypass_q    <= bypass_d;
            idcode_sr_q <= idcode_sr_d;
        end
    end

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// Directed bench for jtag_tap_ctrl: reset, IDCODE read, IR scans, bypass and EXTEST DR scans, TRST abort.
// Latency: inputs change on falling TCK; outputs sampled 1 time unit after rising TCK.
// Backpressure: none; every step is a fixed number of TCK cycles.
module tb_jtag_tap_ctrl;

    logic       TCK = 1'b0;
    logic       TRST, TMS, TDI, bsr_tdo;
    logic       TDO, TDO_en, dr_capture, dr_shift, dr_update, bsr_select, mode;
    logic [3:0] tap_state, ir_out;

    int n_cmp = 0;
    int n_bad = 0;

    jtag_tap_ctrl #(.IR_WIDTH(4), .IDCODE_VAL(32'h1000_0001)) dut (
        .TCK        (TCK),
        .TRST       (TRST),
        .TMS        (TMS),
        .TDI        (TDI),
        .bsr_tdo    (bsr_tdo),
        .TDO        (TDO),
        .TDO_en     (TDO_en),
        .dr_capture (dr_capture),
        .dr_shift   (dr_shift),
        .dr_update  (dr_update),
        .bsr_select (bsr_select),
        .mode       (mode),
        .tap_state  (tap_state),
        .ir_out     (ir_out)
    );

    always #5 TCK = ~TCK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One TCK cycle: drive on the falling edge, return just after the rising edge
    task automatic tick(input logic tms, input logic tdi);
        @(negedge TCK);
        TMS = tms;
        TDI = tdi;
        @(posedge TCK);
        #1;
    endtask

    // IR scan from RTI back to RTI; returns the 4 bits seen on TDO during SH_IR
    task automatic ir_scan(input logic [3:0] val, output logic [3:0] seen);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            seen[i] = TDO;
            tick(i == 3, val[i]);
        end
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
    endtask

    // 8-bit DR scan from RTI back to RTI; bsr_tdo follows bpat, strobes counted at each sample
    task automatic dr_scan(input logic [7:0] din, input logic [7:0] bpat, output logic [7:0] seen,
                           output int n_cap, output int n_sh, output int n_upd);
        n_cap = 0; n_sh = 0; n_upd = 0;
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        n_cap += int'(dr_capture);
        tick(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            bsr_tdo = bpat[i];
            #1;
            seen[i] = TDO;
            n_cap += int'(dr_capture);
            n_sh  += int'(dr_shift);
            tick(i == 7, din[i]);
        end
        n_sh += int'(dr_shift);
        tick(1'b1, 1'b0);
        n_upd += int'(dr_update);
        tick(1'b0, 1'b0);
        n_upd += int'(dr_update);
        n_cap += int'(dr_capture);
    endtask

    logic [31:0] word;
    logic [3:0]  irs;
    logic [7:0]  drs;
    int          en_cnt, c_cap, c_sh, c_upd;

    initial begin
        TRST = 1'b0; TMS = 1'b1; TDI = 1'b0; bsr_tdo = 1'b0;
        #12;
        chk("rst_state", 32'(tap_state), 32'hF);
        chk("rst_ir", 32'(ir_out), 32'h2);
        chk("rst_strobes", {29'd0, dr_capture, dr_shift, dr_update}, 32'h0);
        chk("rst_tdo_en", 32'(TDO_en), 32'h0);
        #2 TRST = 1'b1;

        tick(1'b0, 1'b0);
        chk("rti_state", 32'(tap_state), 32'hC);
        chk("rti_ir", 32'(ir_out), 32'h2);
        chk("rti_strobes", {28'd0, dr_capture, dr_shift, dr_update, TDO_en}, 32'h0);

        // Five TMS=1 from SH_DR must land in TLR
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        chk("shdr_state", 32'(tap_state), 32'h2);
        for (int i = 0; i < 5; i++) tick(1'b1, 1'b0);
        chk("tms5_tlr", 32'(tap_state), 32'hF);
        tick(1'b0, 1'b0);

        // IDCODE read: 32 bits LSB first
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        chk("capdr_state", 32'(tap_state), 32'h6);
        tick(1'b0, 1'b0);
        en_cnt = 0;
        for (int i = 0; i < 32; i++) begin
            word[i] = TDO;
            en_cnt += int'(TDO_en);
            tick(i == 31, 1'b0);
        end
        en_cnt += int'(TDO_en);
        chk("idcode_word", word, 32'h1000_0001);
        chk("idcode_en_cnt", 32'(en_cnt), 32'd32);
        chk("ex1dr_state", 32'(tap_state), 32'h1);
        tick(1'b1, 1'b0);
        chk("upddr_state", 32'(tap_state), 32'h5);
        chk("upd_idcode_nostrobe", 32'(dr_update), 32'h0);
        tick(1'b0, 1'b0);

        // BYPASS via IR=F
        ir_scan(4'hF, irs);
        chk("ir_capture_bits", 32'(irs), 32'h1);
        chk("ir_bypass", 32'(ir_out), 32'hF);
        chk("bypass_sel", {30'd0, bsr_select, mode}, 32'h0);
        dr_scan(8'hCD, 8'hFF, drs, c_cap, c_sh, c_upd);
        chk("bypass_echo", 32'(drs), 32'h9A);
        chk("bypass_strobes", 32'(c_cap + c_sh + c_upd), 32'h0);

        // EXTEST
        ir_scan(4'h0, irs);
        chk("extest_ir", 32'(ir_out), 32'h0);
        chk("extest_sel", {30'd0, bsr_select, mode}, 32'h3);
        dr_scan(8'h00, 8'hA5, drs, c_cap, c_sh, c_upd);
        chk("extest_tdo", 32'(drs), 32'hA5);
        chk("extest_cap_cnt", 32'(c_cap), 32'd1);
        chk("extest_sh_cnt", 32'(c_sh), 32'd8);
        chk("extest_upd_cnt", 32'(c_upd), 32'd1);
        chk("extest_back_rti", 32'(tap_state), 32'hC);

        // Unlisted opcode 5 decodes as BYPASS
        ir_scan(4'h5, irs);
        chk("ir5_sel", {30'd0, bsr_select, mode}, 32'h0);
        dr_scan(8'h3C, 8'hFF, drs, c_cap, c_sh, c_upd);
        chk("ir5_echo", 32'(drs), 32'h78);
        chk("ir5_strobes", 32'(c_cap + c_sh + c_upd), 32'h0);

        // SAMPLE/PRELOAD
        ir_scan(4'h1, irs);
        chk("sample_ir", 32'(ir_out), 32'h1);
        chk("sample_sel", {30'd0, bsr_select, mode}, 32'h2);

        // TRST during SH_DR under EXTEST aborts without update
        ir_scan(4'h0, irs);
        chk("abort_pre_mode", 32'(mode), 32'h1);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b0);
        tick(1'b0, 1'b1);
        chk("abort_in_shdr", {31'd0, dr_shift}, 32'h1);
        #2 TRST = 1'b0;
        #1;
        chk("abort_state", 32'(tap_state), 32'hF);
        chk("abort_ir", 32'(ir_out), 32'h2);
        chk("abort_sel", {30'd0, bsr_select, mode}, 32'h0);
        c_upd = int'(dr_update);
        tick(1'b1, 1'b0);
        c_upd += int'(dr_update);
        #2 TRST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(i == 0, 1'b0);
            c_upd += int'(dr_update);
        end
        chk("abort_no_update", 32'(c_upd), 32'h0);
        chk("abort_recover_rti", 32'(tap_state), 32'hC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
